// File: rtl/serial_parity_rx.sv
// serial_parity_rx
// Receive side of the XOR-parity serial link. Deserialises one framed word
// (start, DATA_W data bits LSB-first, parity, stop) using a one-cycle bit
// strobe from the upstream baud generator. The XOR parity is accumulated over
// the data bits and the received parity bit. The word is then presented with
// parity and framing status.
//
// Interface timing (no back-pressure; the consumer must accept every word):
//   bit_en      one-clk strobe from upstream. rx is sampled and the FSM
//               advances only on clock edges where bit_en=1. With bit_en=0,
//               all state holds.
//   data_valid  one-clk pulse, registered on the edge of the stop-bit strobe.
//               While it is high, data_out/parity_err/frame_err hold the
//               fresh frame result. Those three outputs are held until the
//               next frame completes. data_valid pulses even when an error
//               flag is set; the consumer decides what to do with bad words.

module serial_parity_rx #(
  parameter int DATA_W     = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              rx,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  state_t             state_q;
  state_t             state_d;

  logic [DATA_W-1:0]  shift_q;
  logic [DATA_W-1:0]  shift_next;
  logic [CNT_W-1:0]   count_q;
  logic               acc_q;
  logic               last_data_bit;

  // Decoded per-strobe actions, produced by the FSM output logic
  logic               start_frame;
  logic               take_data;
  logic               take_parity;
  logic               end_frame;

  // The line is LSB-first. Each new bit enters at the MSB. After DATA_W
  // shifts, the first bit received has reached bit 0.
  generate
    if (DATA_W == 1) begin : g_shift_one
      assign shift_next = rx;
    end else begin : g_shift_many
      assign shift_next = {rx, shift_q[DATA_W-1:1]};
    end
  endgenerate

  assign last_data_bit = (count_q == CNT_W'(DATA_W - 1));

  // State register: async reset returns to IDLE and aborts any frame in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: moves only on strobed edges; the strobe is the sole timing
  always_comb begin
    state_d = state_q;
    if (bit_en) begin
      case (state_q)
        S_IDLE: begin
          // No start-bit re-validation. A low sample is a start bit, so a
          // line held low re-triggers a new frame right away.
          if (!rx) begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          if (last_data_bit) begin
            state_d = S_PARITY;
          end
        end
        S_PARITY: begin
          state_d = S_STOP;
        end
        S_STOP: begin
          // A low stop bit is still reported as a word, and the FSM still
          // returns to IDLE.
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Output logic: busy/debug state plus one-hot datapath actions for this strobe
  always_comb begin
    start_frame = 1'b0;
    take_data   = 1'b0;
    take_parity = 1'b0;
    end_frame   = 1'b0;
    busy        = (state_q != S_IDLE);
    state_dbg   = state_q;
    if (bit_en) begin
      case (state_q)
        S_IDLE:   start_frame = ~rx;
        S_DATA:   take_data   = 1'b1;
        S_PARITY: take_parity = 1'b1;
        S_STOP:   end_frame   = 1'b1;
        default:  start_frame = 1'b0;
      endcase
    end
  end

  // Datapath: shift register, bit counter and running XOR parity
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      count_q <= '0;
      acc_q   <= 1'b0;
    end else begin
      if (start_frame) begin
        count_q <= '0;
        acc_q   <= 1'b0;
      end
      if (take_data) begin
        shift_q <= shift_next;
        acc_q   <= acc_q ^ rx;
        count_q <= count_q + CNT_W'(1);
      end
      if (take_parity) begin
        acc_q <= acc_q ^ rx;
      end
    end
  end

  // Result registers: the word and its flags update on the stop-bit strobe only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= end_frame;
      if (end_frame) begin
        data_out   <= shift_q;
        // acc holds XOR of data and parity bit. Even parity expects 0;
        // odd parity expects 1.
        parity_err <= (acc_q != PARITY_ODD);
        frame_err  <= ~rx;
      end
    end
  end

endmodule
